mul_div_unit: RTL



---
 rtl/mul_div_unit_pkg.sv | 30 +++
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_unit_div_step.sv | 17 +
 rtl/mul_div_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the number of radix-2 iterations per operation.
package md_pkg;

  localparam int MD_OP_W  = 3;
  localparam int MD_CNT_W = 6;
  localparam logic [MD_CNT_W-1:0] MD_STEPS = 6'd32;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the pipeline (master) and the multiply/divide unit (slave).
interface mul_div_unit_if
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic [MD_OP_W-1:0]    md_op;
  logic                  start;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi_out;
  logic [DATA_WIDTH-1:0] lo_out;

  modport master (
    output a_in, b_in, md_op, start, flush,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  a_in, b_in, md_op, start, flush,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/mul_div_unit_div_step.sv
// One restoring divide iteration: subtract the divisor from the shifted partial
// remainder when it fits, producing one quotient bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);
  logic [W-1:0] diff;

  // The result always fits in W bits because the partial remainder is below 2*divisor.
  assign diff  = rem_i[W-1:0] - divisor_i;
  assign q_o   = (rem_i >= {1'b0, divisor_i});
  assign rem_o = q_o ? diff : rem_i[W-1:0];
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-step multiply/divide unit with HI/LO result registers.
// state     | meaning
// ST_IDLE   | waiting for start; MTHI/MTLO complete here in one edge
// ST_CALC   | one shift-add / restoring shift-subtract step per cycle on magnitudes
// ST_FINISH | sign correction, HI/LO write, done pulse
module mul_div_unit
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave mdu
);
  localparam int W = DATA_WIDTH;

  state_e              state_q;
  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_OP_W-1:0]  op_q;
  logic [W-1:0]        acc_q, lo_q, m_q, hi_q, lo_out_q;
  logic                neg_res_q, neg_rem_q, done_q;

  logic         signed_op, a_neg, b_neg, is_div, div_q;
  logic [W-1:0] a_mag, b_mag, div_rem, quot_fix, rem_fix;
  logic [W:0]   msum;
  logic [2*W-1:0] prod, prod_fix;

  assign signed_op = md_is_signed(mdu.md_op);
  assign a_neg     = signed_op & mdu.a_in[W-1];
  assign b_neg     = signed_op & mdu.b_in[W-1];
  assign a_mag     = a_neg ? -mdu.a_in : mdu.a_in;
  assign b_mag     = b_neg ? -mdu.b_in : mdu.b_in;
  assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);

  // Multiply keeps {acc_q, lo_q} as the running product with the multiplier shifting out of lo_q.
  assign msum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);

  div_step #(.W(W)) u_div_step (
    .rem_i    ({acc_q, lo_q[W-1]}),
    .divisor_i(m_q),
    .rem_o    (div_rem),
    .q_o      (div_q)
  );

  assign prod     = {acc_q, lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  // Divide by zero: the restoring loop already leaves the dividend in the remainder.
  assign quot_fix = (m_q == '0) ? '1 : (neg_res_q ? -lo_q : lo_q);
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  assign mdu.busy   = (state_q != ST_IDLE);
  assign mdu.done   = done_q;
  assign mdu.hi_out = hi_q;
  assign mdu.lo_out = lo_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_out_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mdu.start) begin
            case (mdu.md_op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q      <= mdu.md_op;
                acc_q     <= '0;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                cnt_q     <= MD_STEPS;
                state_q   <= ST_CALC;
                if ((mdu.md_op == MD_DIV) || (mdu.md_op == MD_DIVU)) begin
                  m_q  <= b_mag;
                  lo_q <= a_mag;
                end else begin
                  m_q  <= a_mag;
                  lo_q <= b_mag;
                end
              end
              MD_MTHI: hi_q     <= mdu.a_in;
              MD_MTLO: lo_out_q <= mdu.a_in;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (mdu.flush) begin
            state_q <= ST_IDLE;
          end else begin
            if (is_div) begin
              acc_q <= div_rem;
              lo_q  <= {lo_q[W-2:0], div_q};
            end else begin
              acc_q <= msum[W:1];
              lo_q  <= {msum[0], lo_q[W-1:1]};
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == MD_CNT_W'(1)) state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          if (!mdu.flush) begin
            done_q <= 1'b1;
            if (is_div) begin
              hi_q     <= rem_fix;
              lo_out_q <= quot_fix;
            end else begin
              {hi_q, lo_out_q} <= prod_fix;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
